mem_ctrl: RTL and testbench

Memory controller between the instruction cache, the MEM stage and the 8-bit single-port RAM. It accepts 4-byte instruction fetch requests from the cache and 1/2/4-byte load/store requests from MEM, arbitrates between them, and sequences the byte-serial RAM bus. It returns assembled little-endian words with one-cycle valid pulses and reports per-requester busy status.

---
 rtl/mem_ctrl.sv | 148 ++++++++++++++
 tb/tb_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetches and MEM loads/stores onto a
// byte-serial single-port RAM, assembling little-endian words for the requesters.
module mem_ctrl #(
   parameter int ADDR_W = 18
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              pc_jump_in,
   input  logic              ic_req_in,
   input  logic [ADDR_W-1:0] ic_addr_in,
   output logic              ic_instE_out,
   output logic [31:0]       ic_inst_out,
   output logic              ic_busy_out,
   input  logic              mem_req_in,
   input  logic              mem_wr_in,
   input  logic [1:0]        mem_len_in,
   input  logic [ADDR_W-1:0] mem_addr_in,
   input  logic [31:0]       mem_wdata_in,
   output logic              mem_dataE_out,
   output logic [31:0]       mem_data_out,
   output logic              mem_busy_out,
   input  logic [7:0]        ram_din_in,
   output logic [7:0]        ram_dout_out,
   output logic [31:0]       ram_addr_out,
   output logic              ram_wr_out
);

   typedef enum logic [1:0] {IDLE, IC_RD, MEM_RD, MEM_WR} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        len_q, len_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;
   logic [31:0]       ic_inst_q, ic_inst_d;
   logic [31:0]       mem_data_q, mem_data_d;
   logic              ic_e_q, ic_e_d;
   logic              mem_e_q, mem_e_d;
   logic [1:0]        lane;
   logic [31:0]       lane_word;

   // NOTE: every variable gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      ic_inst_d  = ic_inst_q;
      mem_data_d = mem_data_q;
      ic_e_d     = 1'b0;
      mem_e_d    = 1'b0;
      // The RAM answers one cycle late, so the byte seen now belongs to lane cnt-1.
      lane       = 2'(cnt_q - 3'd1);
      lane_word  = {24'b0, ram_din_in} << {lane, 3'b000};

      case (state_q)
         IDLE: begin
            if (mem_req_in) begin
               state_d = mem_wr_in ? MEM_WR : MEM_RD;
               addr_d  = mem_addr_in;
               len_d   = (mem_len_in == 2'b00) ? 3'd1 :
                         (mem_len_in == 2'b01) ? 3'd2 : 3'd4;
               wdata_d = mem_wdata_in;
               cnt_d   = 3'd0;
               buf_d   = '0;
            end else if (ic_req_in && !pc_jump_in) begin
               state_d = IC_RD;
               addr_d  = ic_addr_in;
               len_d   = 3'd4;
               cnt_d   = 3'd0;
               buf_d   = '0;
            end
         end
         IC_RD, MEM_RD: begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q + 3'd1;
            if (cnt_q != 3'd0) buf_d = buf_q | lane_word;
            if (state_q == IC_RD && pc_jump_in) begin
               state_d = IDLE;
            end else if (cnt_q == len_q) begin
               state_d = IDLE;
               if (state_q == IC_RD) begin
                  ic_inst_d = buf_d;
                  ic_e_d    = 1'b1;
               end else begin
                  mem_data_d = buf_d;
                  mem_e_d    = 1'b1;
               end
            end
         end
         MEM_WR: begin
            addr_d  = addr_q + ADDR_W'(1);
            cnt_d   = cnt_q + 3'd1;
            wdata_d = wdata_q >> 8;
            if (cnt_q == len_q - 3'd1) begin
               state_d = IDLE;
               mem_e_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         len_q      <= '0;
         wdata_q    <= '0;
         buf_q      <= '0;
         ic_inst_q  <= '0;
         mem_data_q <= '0;
         ic_e_q     <= 1'b0;
         mem_e_q    <= 1'b0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         wdata_q    <= wdata_d;
         buf_q      <= buf_d;
         ic_inst_q  <= ic_inst_d;
         mem_data_q <= mem_data_d;
         ic_e_q     <= ic_e_d;
         mem_e_q    <= mem_e_d;
      end
   end

   assign ic_instE_out  = ic_e_q;
   assign ic_inst_out   = ic_inst_q;
   assign ic_busy_out   = (state_q == IC_RD);
   assign mem_dataE_out = mem_e_q;
   assign mem_data_out  = mem_data_q;
   assign mem_busy_out  = (state_q == MEM_RD) || (state_q == MEM_WR);
   assign ram_dout_out  = wdata_q[7:0];
   assign ram_addr_out  = 32'(addr_q);
   // A stalled cycle must not repeat the write, so the strobe is gated by rdy.
   assign ram_wr_out    = (state_q == MEM_WR) && rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-serial RAM environment plus a transaction-level
// reference of memory contents, latencies and assembled words.
module tb_mem_ctrl;

   localparam int AW  = 18;
   localparam int MSZ = 1 << AW;

   logic          clk_in = 1'b0;
   logic          rst_in, rdy_in, pc_jump_in;
   logic          ic_req_in, ic_instE_out, ic_busy_out;
   logic [AW-1:0] ic_addr_in, mem_addr_in;
   logic [31:0]   ic_inst_out, mem_wdata_in, mem_data_out, ram_addr_out;
   logic          mem_req_in, mem_wr_in, mem_dataE_out, mem_busy_out, ram_wr_out;
   logic [1:0]    mem_len_in;
   logic [7:0]    ram_din_in, ram_dout_out;

   mem_ctrl #(.ADDR_W(AW)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .pc_jump_in(pc_jump_in),
      .ic_req_in(ic_req_in), .ic_addr_in(ic_addr_in), .ic_instE_out(ic_instE_out),
      .ic_inst_out(ic_inst_out), .ic_busy_out(ic_busy_out),
      .mem_req_in(mem_req_in), .mem_wr_in(mem_wr_in), .mem_len_in(mem_len_in),
      .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
      .mem_dataE_out(mem_dataE_out), .mem_data_out(mem_data_out),
      .mem_busy_out(mem_busy_out), .ram_din_in(ram_din_in), .ram_dout_out(ram_dout_out),
      .ram_addr_out(ram_addr_out), .ram_wr_out(ram_wr_out)
   );

   always #5 clk_in = ~clk_in;

   // Power-up RAM content pattern, shared by the RAM and the reference.
   function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
      return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ {6'b0, a[17:16]};
   endfunction

   logic [7:0]    ram [MSZ];
   bit            ram_set [MSZ];
   logic [AW-1:0] ra;
   assign ra = ram_addr_out[AW-1:0];

   always @(posedge clk_in) begin
      if (rdy_in) begin
         if (ram_wr_out) begin
            ram[ra]     <= ram_dout_out;
            ram_set[ra] <= 1'b1;
         end
         ram_din_in <= ram_set[ra] ? ram[ra] : init_byte(ra);
      end
   end

   logic [7:0]  model [MSZ];
   bit          model_set [MSZ];
   logic [31:0] last_ic, last_mem;
   int          n_cmp, n_bad;

   function automatic logic [7:0] model_rd(input logic [AW-1:0] a);
      return model_set[a] ? model[a] : init_byte(a);
   endfunction

   function automatic int len_bytes(input logic [1:0] lc);
      return (lc == 2'b00) ? 1 : (lc == 2'b01) ? 2 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // kind: 0 = fetch, 1 = load, 2 = store
   task automatic issue(input int kind, input logic [AW-1:0] a, input logic [1:0] lc,
                        input logic [31:0] wd);
      @(negedge clk_in);
      if (kind == 0) begin
         ic_req_in  = 1'b1;
         ic_addr_in = a;
      end else begin
         mem_req_in   = 1'b1;
         mem_wr_in    = (kind == 2);
         mem_len_in   = lc;
         mem_addr_in  = a;
         mem_wdata_in = wd;
      end
   endtask

   // Follows an accepted access cycle by cycle from c0 until its pulse.
   task automatic track(input int kind, input logic [AW-1:0] a, input int n,
                        input logic [31:0] wd, input int jump_at,
                        input int stall_at, input int stall_len);
      bit            rd = (kind != 2);
      int            done_k = rd ? n + 1 : n;
      logic [31:0]   exp_w = '0;
      logic [AW-1:0] aj;
      logic          busy, pulse, other_busy, exp_wr;
      int            k = 0;
      int            stall_left = 0;
      bit            stall_done = 1'b0;
      bit            finished = 1'b0;
      bit            jumped = 1'b0;

      for (int j = 0; j < n; j++) begin
         aj = a + AW'(j);
         exp_w |= 32'(model_rd(aj)) << (8 * j);
      end

      for (int t = 0; t < 64 && !finished; t++) begin
         @(negedge clk_in);
         if (t == 0) begin
            if (kind == 0) ic_req_in = 1'b0;
            else mem_req_in = 1'b0;
         end
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) rdy_in = 1'b1;
         end else if (!stall_done && stall_at >= 0 && k == stall_at) begin
            rdy_in     = 1'b0;
            stall_left = stall_len;
            stall_done = 1'b1;
         end
         if (kind == 0 && jump_at >= 0 && k == jump_at) pc_jump_in = 1'b1;
         #1;
         busy       = (kind == 0) ? ic_busy_out : mem_busy_out;
         pulse      = (kind == 0) ? ic_instE_out : mem_dataE_out;
         other_busy = (kind == 0) ? mem_busy_out : ic_busy_out;
         check("other_busy", 32'(other_busy), 32'd0);
         if (t == 0) begin
            if (kind == 0) check("mem_data_hold", mem_data_out, last_mem);
            else check("ic_inst_hold", ic_inst_out, last_ic);
         end
         if (k < done_k) begin
            check("busy", 32'(busy), 32'd1);
            check("early_pulse", 32'(pulse), 32'd0);
            if (k < n) begin
               aj = a + AW'(k);
               check("ram_addr", ram_addr_out, 32'(aj));
            end
            exp_wr = (kind == 2) && (k < n) && rdy_in;
            check("ram_wr", 32'(ram_wr_out), 32'(exp_wr));
            if (exp_wr) check("ram_dout", 32'(ram_dout_out), 32'(wd[8*k +: 8]));
         end else begin
            check("busy_at_pulse", 32'(busy), 32'd0);
            check("pulse", 32'(pulse), 32'd1);
            check("ram_wr_idle", 32'(ram_wr_out), 32'd0);
            if (kind == 0) begin
               check("ic_word", ic_inst_out, exp_w);
               last_ic = exp_w;
            end else if (kind == 1) begin
               check("mem_word", mem_data_out, exp_w);
               last_mem = exp_w;
            end else begin
               check("store_data_hold", mem_data_out, last_mem);
            end
            finished = 1'b1;
         end
         if (!finished && pc_jump_in) begin
            @(negedge clk_in);
            pc_jump_in = 1'b0;
            #1;
            check("jump_busy", 32'(ic_busy_out), 32'd0);
            check("jump_ram_wr", 32'(ram_wr_out), 32'd0);
            for (int i = 0; i < 5; i++) begin
               check("jump_no_pulse", 32'(ic_instE_out), 32'd0);
               @(negedge clk_in);
               #1;
            end
            jumped   = 1'b1;
            finished = 1'b1;
         end else if (rdy_in) begin
            k++;
         end
      end

      if (!finished) begin
         n_cmp++;
         n_bad++;
         $display("FAIL timeout: access kind %0d at %h never completed", kind, a);
      end else if (kind == 2 && !jumped) begin
         for (int j = 0; j < n; j++) begin
            aj = a + AW'(j);
            model[aj]     = wd[8*j +: 8];
            model_set[aj] = 1'b1;
         end
      end
   endtask

   task automatic run(input int kind, input logic [AW-1:0] a, input logic [1:0] lc,
                      input logic [31:0] wd, input int jump_at, input int stall_at,
                      input int stall_len);
      issue(kind, a, lc, wd);
      track(kind, a, (kind == 0) ? 4 : len_bytes(lc), wd, jump_at, stall_at, stall_len);
   endtask

   initial begin
      int            kind, n, jump_at, stall_at;
      logic [AW-1:0] a;
      logic [1:0]    lc;

      n_cmp = 0; n_bad = 0; last_ic = '0; last_mem = '0;
      rst_in = 1'b0; rdy_in = 1'b1; pc_jump_in = 1'b0;
      ic_req_in = 1'b0; ic_addr_in = '0;
      mem_req_in = 1'b0; mem_wr_in = 1'b0; mem_len_in = 2'b00;
      mem_addr_in = '0; mem_wdata_in = '0;

      repeat (3) @(negedge clk_in);
      #1;
      check("rst_ic_busy", 32'(ic_busy_out), 32'd0);
      check("rst_mem_busy", 32'(mem_busy_out), 32'd0);
      check("rst_ic_pulse", 32'(ic_instE_out), 32'd0);
      check("rst_mem_pulse", 32'(mem_dataE_out), 32'd0);
      check("rst_ic_inst", ic_inst_out, 32'd0);
      check("rst_mem_data", mem_data_out, 32'd0);
      check("rst_ram_addr", ram_addr_out, 32'd0);
      check("rst_ram_wr", 32'(ram_wr_out), 32'd0);
      rst_in = 1'b1;

      // Preload through the controller itself.
      run(2, 18'h00100, 2'b11, 32'h00A00513, -1, -1, 0);
      run(2, 18'h00200, 2'b01, 32'h00001234, -1, -1, 0);
      run(2, 18'h00010, 2'b00, 32'h0000007F, -1, -1, 0);

      run(0, 18'h00100, 2'b11, 32'h0, -1, -1, 0);
      check("fetch_word_literal", ic_inst_out, 32'h00A00513);

      // Simultaneous requests: MEM first, fetch accepted right after the pulse.
      @(negedge clk_in);
      mem_req_in = 1'b1; mem_wr_in = 1'b0; mem_len_in = 2'b01; mem_addr_in = 18'h00200;
      ic_req_in = 1'b1; ic_addr_in = 18'h00100;
      track(1, 18'h00200, 2, 32'h0, -1, -1, 0);
      check("simul_load_literal", mem_data_out, 32'h00001234);
      track(0, 18'h00100, 4, 32'h0, -1, -1, 0);

      // Store across the top of the address space, then read it back.
      run(2, 18'h3FFFE, 2'b11, 32'hDEADBEEF, -1, -1, 0);
      run(1, 18'h3FFFE, 2'b10, 32'h0, -1, -1, 0);
      check("wrap_word_literal", mem_data_out, 32'hDEADBEEF);
      run(1, 18'h00000, 2'b01, 32'h0, -1, -1, 0);
      check("wrap_low_literal", mem_data_out, 32'h0000DEAD);

      // Cancelled fetch, then a normal one.
      run(0, 18'h00100, 2'b11, 32'h0, 2, -1, 0);
      run(0, 18'h00100, 2'b11, 32'h0, -1, -1, 0);

      // Reset in c2 of a store: two bytes land, the rest are aborted.
      issue(2, 18'h00400, 2'b11, 32'hCAFEF00D);
      @(negedge clk_in); mem_req_in = 1'b0;
      @(negedge clk_in);
      @(negedge clk_in); rst_in = 1'b0;
      #1;
      check("mid_rst_ram_wr", 32'(ram_wr_out), 32'd0);
      check("mid_rst_mem_busy", 32'(mem_busy_out), 32'd0);
      check("mid_rst_ram_addr", ram_addr_out, 32'd0);
      check("mid_rst_dout", 32'(ram_dout_out), 32'd0);
      check("mid_rst_mem_data", mem_data_out, 32'd0);
      check("mid_rst_ic_inst", ic_inst_out, 32'd0);
      model[18'h00400] = 8'h0D; model_set[18'h00400] = 1'b1;
      model[18'h00401] = 8'hF0; model_set[18'h00401] = 1'b1;
      last_ic = '0; last_mem = '0;
      @(negedge clk_in); rst_in = 1'b1;
      run(1, 18'h00010, 2'b00, 32'h0, -1, -1, 0);
      check("post_rst_load_literal", mem_data_out, 32'h0000007F);
      run(1, 18'h00400, 2'b11, 32'h0, -1, -1, 0);

      // Three-cycle stall in c2 of a fetch, and one in the middle of a store.
      run(0, 18'h00100, 2'b11, 32'h0, -1, 2, 3);
      run(2, 18'h00500, 2'b11, 32'h01020304, -1, 1, 2);
      run(1, 18'h00500, 2'b11, 32'h0, -1, -1, 0);

      for (int i = 0; i < 60; i++) begin
         kind = int'($urandom_range(0, 2));
         a    = ($urandom_range(0, 3) == 0) ? AW'(18'h3FFFC + $urandom_range(0, 3))
                                            : AW'($urandom_range(0, 16'hFFFF));
         lc   = 2'($urandom_range(0, 3));
         n    = (kind == 0) ? 4 : len_bytes(lc);
         jump_at  = (kind == 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
         stall_at = (jump_at < 0 && $urandom_range(0, 3) == 0) ?
                    int'($urandom_range(0, n - 1)) : -1;
         run(kind, a, lc, $urandom, jump_at, stall_at, int'($urandom_range(1, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
